// File: rtl/ysyx_22050710_mem_arbiter.sv
// N-channel request arbiter onto one shared memory port, one transaction in flight; YSYX_22050710_ARB_RR_EN selects round-robin (else fixed priority, ch0 highest).
// Latency: accept t, mem handshake >= t+1, response pulse one cycle after i_mem_resp_valid or watchdog expiry.
// Backpressure: o_req_ready is low outside IDLE; o_mem_* are held stable until i_mem_req_ready.
module ysyx_22050710_mem_arbiter #(
    parameter int CH_NUM      = 2,
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 64,
    parameter int WMASK_WD    = 8,
    parameter int TIMEOUT_CYC = 255,
    parameter int CH_ID_WD    = $clog2(CH_NUM)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [CH_NUM-1:0]            i_req_valid,
    output logic [CH_NUM-1:0]            o_req_ready,
    input  logic [CH_NUM*ADDR_WD-1:0]    i_req_addr,
    input  logic [CH_NUM-1:0]            i_req_wen,
    input  logic [CH_NUM*WMASK_WD-1:0]   i_req_wmask,
    input  logic [CH_NUM*DATA_WD-1:0]    i_req_wdata,
    output logic [CH_NUM-1:0]            o_resp_valid,
    output logic [DATA_WD-1:0]           o_resp_rdata,
    output logic                         o_resp_err,
    output logic                         o_mem_req_valid,
    input  logic                         i_mem_req_ready,
    output logic [ADDR_WD-1:0]           o_mem_addr,
    output logic                         o_mem_wen,
    output logic [WMASK_WD-1:0]          o_mem_wmask,
    output logic [DATA_WD-1:0]           o_mem_wdata,
    input  logic                         i_mem_resp_valid,
    input  logic [DATA_WD-1:0]           i_mem_resp_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_WD = $clog2(TIMEOUT_CYC + 2);
    localparam int LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(LAST_I);

    logic [1:0]          state_q, state_d;
    logic [CH_ID_WD-1:0] owner_q, owner_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic [ADDR_WD-1:0]  mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [WMASK_WD-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_WD-1:0]  mem_wdata_q, mem_wdata_d;
    logic [CH_NUM-1:0]   resp_vld_q, resp_vld_d;
    logic [DATA_WD-1:0]  resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                grant_vld;
    logic [CH_ID_WD-1:0] grant_idx;
    logic [CH_NUM-1:0]   grant_oh;
    logic [CH_NUM-1:0]   owner_oh;
    logic                timeout_hit;
    int                  cand;

`ifdef YSYX_22050710_ARB_RR_EN
    logic [CH_ID_WD-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = CH_NUM; k >= 1; k--) begin
`ifdef YSYX_22050710_ARB_RR_EN
            cand = (int'(rr_ptr_q) + k) % CH_NUM;
`else
            cand = k - 1;
`endif
            if (i_req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = CH_ID_WD'(cand);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        owner_oh = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            grant_oh[k] = grant_vld && (grant_idx == CH_ID_WD'(k));
            owner_oh[k] = (owner_q == CH_ID_WD'(k));
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_vld_d   = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
`ifdef YSYX_22050710_ARB_RR_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    mem_addr_d  = i_req_addr[int'(grant_idx)*ADDR_WD +: ADDR_WD];
                    mem_wen_d   = i_req_wen[grant_idx];
                    mem_wmask_d = i_req_wmask[int'(grant_idx)*WMASK_WD +: WMASK_WD];
                    mem_wdata_d = i_req_wdata[int'(grant_idx)*DATA_WD +: DATA_WD];
                    owner_d     = grant_idx;
`ifdef YSYX_22050710_ARB_RR_EN
                    rr_ptr_d    = grant_idx;
`endif
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_WD'(1);
                // A real response beats a coincident watchdog expiry.
                if (i_mem_resp_valid) begin
                    resp_vld_d   = owner_oh;
                    resp_rdata_d = i_mem_resp_rdata;
                    state_d      = ST_IDLE;
                end else if (timeout_hit) begin
                    resp_vld_d   = owner_oh;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wmask_q  <= '0;
            mem_wdata_q  <= '0;
            resp_vld_q   <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef YSYX_22050710_ARB_RR_EN
            rr_ptr_q     <= CH_ID_WD'(CH_NUM - 1);
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_vld_q   <= resp_vld_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef YSYX_22050710_ARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign o_req_ready     = (state_q == ST_IDLE) ? grant_oh : '0;
    assign o_mem_req_valid = (state_q == ST_REQ);
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wen       = mem_wen_q;
    assign o_mem_wmask     = mem_wmask_q;
    assign o_mem_wdata     = mem_wdata_q;
    assign o_resp_valid    = resp_vld_q;
    assign o_resp_rdata    = resp_rdata_q;
    assign o_resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Directed bench for ysyx_22050710_mem_arbiter: scoreboard of expected responses popped on each o_resp_valid pulse.
// A second instance with the watchdog disabled covers the long-wait case.
module tb_ysyx_22050710_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [63:0]  req_addr = '0;
    logic [1:0]   req_wen = '0;
    logic [15:0]  req_wmask = '0;
    logic [127:0] req_wdata = '0;
    logic [1:0]   resp_valid;
    logic [63:0]  resp_rdata;
    logic         resp_err;
    logic         mem_req_valid;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_addr;
    logic         mem_wen;
    logic [7:0]   mem_wmask;
    logic [63:0]  mem_wdata;
    logic         mem_resp_valid = 1'b0;
    logic [63:0]  mem_resp_rdata = '0;

    logic [1:0]   req_valid2 = '0;
    logic [1:0]   req_ready2;
    logic [1:0]   resp_valid2;
    logic [63:0]  resp_rdata2;
    logic         resp_err2;
    logic         mem_req_valid2;
    logic         mem_ready2 = 1'b0;
    logic [31:0]  mem_addr2;
    logic         mem_wen2;
    logic [7:0]   mem_wmask2;
    logic [63:0]  mem_wdata2;
    logic         mem_resp_valid2 = 1'b0;
    logic [63:0]  mem_resp_rdata2 = '0;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   last_g = 1;

    always #5 clk = ~clk;

    ysyx_22050710_mem_arbiter #(.TIMEOUT_CYC(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wmask(req_wmask), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_ready),
        .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wmask(mem_wmask), .o_mem_wdata(mem_wdata),
        .i_mem_resp_valid(mem_resp_valid), .i_mem_resp_rdata(mem_resp_rdata)
    );

    ysyx_22050710_mem_arbiter #(.TIMEOUT_CYC(0)) u_dut_nowd (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid2), .o_req_ready(req_ready2),
        .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wmask(req_wmask), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid2), .o_resp_rdata(resp_rdata2), .o_resp_err(resp_err2),
        .o_mem_req_valid(mem_req_valid2), .i_mem_req_ready(mem_ready2),
        .o_mem_addr(mem_addr2), .o_mem_wen(mem_wen2), .o_mem_wmask(mem_wmask2), .o_mem_wdata(mem_wdata2),
        .i_mem_resp_valid(mem_resp_valid2), .i_mem_resp_rdata(mem_resp_rdata2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [1:0] v);
`ifdef YSYX_22050710_ARB_RR_EN
        for (int k = 1; k <= 2; k++)
            if (v[(last_g + k) % 2]) return (last_g + k) % 2;
`else
        for (int k = 0; k < 2; k++)
            if (v[k]) return k;
`endif
        return 0;
    endfunction

    task automatic set_ch(input int ch, input logic [31:0] a, input logic w,
                          input logic [7:0] m, input logic [63:0] d);
        req_addr[ch*32 +: 32]  = a;
        req_wen[ch]            = w;
        req_wmask[ch*8 +: 8]   = m;
        req_wdata[ch*64 +: 64] = d;
    endtask

    // Raise one channel, wait for its grant, push the expected response, then drop valid.
    task automatic issue(input int ch, input logic [31:0] a, input logic w, input logic [7:0] m,
                         input logic [63:0] d, input logic [63:0] rsp, input logic err);
        int   n;
        exp_t e;
        set_ch(ch, a, w, m, d);
        req_valid[ch] = 1'b1;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("grant", {62'd0, req_ready}, 64'd1 << model_grant(req_valid));
        e.ch = ch; e.data = rsp; e.err = err;
        exp_q.push_back(e);
        last_g = ch;
        step();
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_mem_req();
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    endtask

    task automatic mem_serve(input int rdly, input int sdly, input logic [63:0] rsp,
                             input logic [31:0] ea, input logic ew, input logic [7:0] em,
                             input logic [63:0] ed);
        wait_mem_req();
        for (int i = 0; i <= rdly; i++) begin
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, ea});
            chk("mem_wen", {63'd0, mem_wen}, {63'd0, ew});
            chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, em});
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_valid_hold", {63'd0, mem_req_valid}, 64'd1);
            chk("req_ready_busy", {62'd0, req_ready}, 64'd0);
            if (i < rdly) step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < sdly; i++) step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rsp;
        step();
        mem_resp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("stale_resp", {62'd0, resp_valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_owner", {62'd0, resp_valid}, 64'd1 << mon_e.ch);
                chk("resp_rdata", resp_rdata, mon_e.data);
                chk("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
            end
        end
    end

    initial begin
        int n;
        int seen;
        int g;
        exp_t e;

        // Reset state
        #1;
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single read on ch1
        issue(1, 32'h8000_0010, 1'b0, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0);
        mem_serve(1, 2, 64'hDEAD_BEEF_0000_0001, 32'h8000_0010, 1'b0, 8'h00, 64'd0);

        // Write under 5 cycles of backpressure; ch1 waves a request it withdraws
        issue(0, 32'h8000_0100, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0ACC, 1'b0);
        set_ch(1, 32'h9000_0000, 1'b0, 8'h00, 64'd0);
        req_valid[1] = 1'b1;
        mem_serve(5, 1, 64'h0000_0000_0000_0ACC, 32'h8000_0100, 1'b1, 8'h0F, 64'h1122_3344_5566_7788);
        req_valid[1] = 1'b0;
        step();
        chk("drop_no_accept", {63'd0, mem_req_valid}, 64'd0);

        // Watchdog expiry, then a stale response that must be ignored
        issue(0, 32'h8000_0200, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
        wait_mem_req();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("to_early", {62'd0, resp_valid}, 64'd0);
        end
        step();
        chk("to_pulse", {62'd0, resp_valid}, 64'd1);
        chk("to_err", {63'd0, resp_err}, 64'd1);
        chk("to_rdata", resp_rdata, 64'd0);
        step();
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h5555_5555_5555_5555;
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("stale_ignored", {62'd0, resp_valid}, 64'd0);
        chk("stale_idle", {63'd0, mem_req_valid}, 64'd0);
        issue(1, 32'h8000_0300, 1'b0, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
        mem_serve(0, 0, 64'h0123_4567_89AB_CDEF, 32'h8000_0300, 1'b0, 8'h00, 64'd0);

        // Response lands on the final watchdog cycle: data wins
        issue(1, 32'h8000_0400, 1'b0, 8'h00, 64'd0, 64'hCAFE_F00D_0000_0004, 1'b0);
        mem_serve(0, 3, 64'hCAFE_F00D_0000_0004, 32'h8000_0400, 1'b0, 8'h00, 64'd0);

        // Asynchronous reset in RESP
        issue(1, 32'h8000_0500, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
        wait_mem_req();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("arst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("arst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("arst_resp_rdata", resp_rdata, 64'd0);
        chk("arst_req_ready", {62'd0, req_ready}, 64'd0);
        exp_q.delete();
        last_g = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_no_resp", {62'd0, resp_valid}, 64'd0);

        // Contention: both channels held valid for four transactions
        set_ch(0, 32'hA000_0000, 1'b0, 8'h00, 64'd0);
        set_ch(1, 32'hB000_0000, 1'b0, 8'h00, 64'd0);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 20) begin
                step();
                #1;
                n++;
            end
            g = model_grant(2'b11);
            chk("cont_grant", {62'd0, req_ready}, 64'd1 << g);
            e.ch = g; e.data = 64'h100 + 64'(t); e.err = 1'b0;
            exp_q.push_back(e);
            last_g = g;
            step();
            mem_serve(0, 0, 64'h100 + 64'(t), (g == 0) ? 32'hA000_0000 : 32'hB000_0000,
                      1'b0, 8'h00, 64'd0);
            if (t == 3) req_valid = 2'b00;
        end
        step();
        step();

        // Watchdog disabled: a 1000-cycle wait still delivers the response
        set_ch(0, 32'hC000_0000, 1'b0, 8'h00, 64'd0);
        req_valid2 = 2'b01;
        n = 0;
        #1;
        while (req_ready2 == 2'b00 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("nowd_grant", {62'd0, req_ready2}, 64'd1);
        step();
        req_valid2 = 2'b00;
        chk("nowd_mem_valid", {63'd0, mem_req_valid2}, 64'd1);
        mem_ready2 = 1'b1;
        step();
        mem_ready2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (resp_valid2 != 2'b00) seen++;
        end
        chk("nowd_no_timeout", 64'(seen), 64'd0);
        mem_resp_valid2 = 1'b1;
        mem_resp_rdata2 = 64'hFEED_0000_0000_1000;
        step();
        mem_resp_valid2 = 1'b0;
        chk("nowd_resp", {62'd0, resp_valid2}, 64'd1);
        chk("nowd_err", {63'd0, resp_err2}, 64'd0);
        chk("nowd_rdata", resp_rdata2, 64'hFEED_0000_0000_1000);

        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_mem_arbiter.md
Name: ysyx_22050710_mem_arbiter

Overview:
Parametrised N-channel memory request arbiter merging the core's independent inst and data SRAM ports (plus future masters such as a DMA or CSR walker) onto one shared variable-latency memory port. Upstream side is per-channel valid/ready request plus response pulse. Downstream side is a req/ready + resp_valid handshake. One transaction is in flight at a time, with a watchdog timeout. Sits between the core top and the memory/bus bridge.

Parameters:
CH_NUM, 2, number of requesting channels (>=2; ch0 = inst, ch1 = data by convention)
ADDR_WD, 32, request address width
DATA_WD, 64, read/write data width
WMASK_WD, 8, write byte-mask width (DATA_WD/8)
TIMEOUT_CYC, 255, max cycles waiting for a response; 0 disables the watchdog
CH_ID_WD, $clog2(CH_NUM), owner index width (derived, not overridden)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  CH_NUM  per-channel request valid
o_req_ready  out  CH_NUM  per-channel accept; one-hot or zero
i_req_addr  in  CH_NUM*ADDR_WD  flattened addresses, ch k at [k*ADDR_WD +: ADDR_WD]
i_req_wen  in  CH_NUM  1 = write, 0 = read
i_req_wmask  in  CH_NUM*WMASK_WD  flattened byte masks
i_req_wdata  in  CH_NUM*DATA_WD  flattened write data
o_resp_valid  out  CH_NUM  one-cycle response pulse to the owning channel
o_resp_rdata  out  DATA_WD  shared response data, valid with o_resp_valid
o_resp_err  out  1  response is a timeout error, valid with o_resp_valid
o_mem_req_valid  out  1  downstream request valid
i_mem_req_ready  in  1  downstream accepts request
o_mem_addr  out  ADDR_WD  registered request address
o_mem_wen  out  1  registered write enable
o_mem_wmask  out  WMASK_WD  registered mask
o_mem_wdata  out  DATA_WD  registered write data
i_mem_resp_valid  in  1  downstream response (read data or write ack)
i_mem_resp_rdata  in  DATA_WD  downstream read data

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; all o_* valids/ready 0; o_mem_* fields 0; o_resp_rdata 0; o_resp_err 0; timeout counter 0; RR pointer = CH_NUM-1 (ch0 wins first).
- FSM IDLE -> REQ -> RESP -> IDLE.
- IDLE: o_req_ready is combinational, asserted only for the winner g among set i_req_valid bits. Handshake completes in that same cycle. Channel g's addr/wen/wmask/wdata are registered into o_mem_*; owner <= g; next state REQ. No valid set: stay IDLE, o_req_ready = 0.
- REQ: o_mem_req_valid = 1; o_mem_* held stable until i_mem_req_ready. At the handshake, move to RESP and clear the counter. o_req_ready = 0 in REQ and RESP.
- RESP: counter increments each cycle. If i_mem_resp_valid is high, the next cycle has o_resp_valid[owner] = 1, o_resp_rdata = i_mem_resp_rdata and o_resp_err = 0, and state is IDLE. Writes also complete on i_mem_resp_valid.
- Timeout: TIMEOUT_CYC != 0 and counter reaches TIMEOUT_CYC-1 without a response. Next cycle has o_resp_valid[owner] = 1, o_resp_err = 1, o_resp_rdata = 0, and state is IDLE.
- If response and timeout land on the same cycle, the response wins (err = 0).
- i_mem_resp_valid in IDLE or REQ (late or stale) is discarded without effect.
- o_resp_valid / o_resp_err are single-cycle, registered. The IDLE accept may coincide with a response pulse.
- Best-case latency: accept t, mem handshake t+1, resp t+2, o_resp_valid t+3. Next accept is possible at t+3.
- Upstream may drop i_req_valid before it is accepted; no state changes.
- Reset mid-transaction aborts it: no response is issued. Downstream must tolerate the abandoned request.

Optional Feature:
YSYX_22050710_ARB_RR_EN
- Defined: round-robin arbitration. Search starts at (last_grant+1) mod CH_NUM. last_grant is updated on each IDLE accept.
- Undefined: fixed priority, lowest index wins (ch0 highest). The RR pointer register is not built.

Test Plan:
- Single read: ch1 addr 0x8000_0010, wen 0; mem ready 1 cycle later, resp 0xDEAD_BEEF_0000_0001 after 3 cycles -> o_mem_addr = 0x8000_0010 held through REQ; o_resp_valid = 2'b10 for exactly 1 cycle; rdata matches; err = 0.
- Contention: ch0 and ch1 both valid continuously, 4 transactions -> fixed-priority build grants 0,0,0,0; RR_EN build grants 0,1,0,1.
- Backpressure: i_mem_req_ready low 5 cycles on a write (wmask 0x0F, wdata 0x1122334455667788) -> o_mem_* stable for all 5 cycles; o_req_ready = 0 throughout; ack yields o_resp_valid to the owner.
- Timeout: TIMEOUT_CYC = 4, no response -> o_resp_err = 1, rdata = 0 on owner 4 cycles after mem handshake. A resp arriving 2 cycles later is ignored, and the next request proceeds normally.
- Edge: response on the same cycle the counter hits TIMEOUT_CYC-1 -> err = 0 and data delivered. TIMEOUT_CYC = 0 with a 1000-cycle wait -> no error, response delivered.
- Reset: assert i_rst_n low asynchronously during RESP -> all outputs 0 immediately. After release, ch0 wins first and no stale o_resp_valid appears.
